// File: rtl/rad4_ifft_bfly.sv
// Inverse radix-4 butterfly: conjugate-twiddle stage followed by two halving add/sub
// stages, run as a 3-stage valid/ready pipeline with a single global stall.
module rad4_ifft_bfly (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] Y0,
  input  logic [31:0] Y1,
  input  logic [31:0] Y2,
  input  logic [31:0] Y3,
  input  logic [31:0] W1K,
  input  logic [31:0] W2K,
  input  logic [31:0] W3K,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] A0,
  output logic [31:0] A1,
  output logic [31:0] A2,
  output logic [31:0] A3
);

  logic        s1_valid, s2_valid;
  logic [31:0] s1_c0, s1_c1, s1_c2, s1_c3;
  logic [31:0] s2_b0, s2_b1, s2_b2, s2_b3;

  function automatic logic [15:0] sat16(input logic signed [33:0] x);
    if (x > 34'sd32767)  return 16'h7fff;
    if (x < -34'sd32768) return 16'h8000;
    return x[15:0];
  endfunction

  // a * conj(w) with w in Q1.14, round-half-up then saturate each part.
  function automatic logic [31:0] conj_mul(input logic [31:0] a, input logic [31:0] w);
    logic signed [33:0] ar, ai, wr, wi, re_full, im_full;
    ar = {{18{a[31]}}, a[31:16]};
    ai = {{18{a[15]}}, a[15:0]};
    wr = {{18{w[31]}}, w[31:16]};
    wi = {{18{w[15]}}, w[15:0]};
    re_full = ar * wr + ai * wi + 34'sd8192;
    im_full = ai * wr - ar * wi + 34'sd8192;
    return {sat16(re_full >>> 14), sat16(im_full >>> 14)};
  endfunction

  // 17-bit sum or difference, then drop the LSB (arithmetic shift, rounds toward -inf).
  function automatic logic [15:0] half(input logic [15:0] a, input logic [15:0] b,
                                       input logic sub);
    logic [16:0] s;
    s = sub ? {a[15], a} - {b[15], b} : {a[15], a} + {b[15], b};
    return s[16:1];
  endfunction

  function automatic logic [31:0] cadd_half(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    return {half(a[31:16], b[31:16], sub), half(a[15:0], b[15:0], sub)};
  endfunction

  function automatic logic [15:0] neg_sat16(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7fff : 16'h0000 - x;
  endfunction

  // Multiply by -j: (re, im) -> (im, -re).
  function automatic logic [31:0] rot_neg_j(input logic [31:0] x);
    return {x[15:0], neg_sat16(x[31:16])};
  endfunction

  assign IN_READY = !OUT_VALID || OUT_READY;

  // NOTE: S1/S2 data needs no reset because every consumer qualifies it with a
  // stage valid bit; only the valid bits and the visible outputs are cleared.
  always_ff @(posedge CLK) begin
    if (IN_READY) begin
      if (IN_VALID) begin
        s1_c0 <= Y0;
        s1_c1 <= conj_mul(Y1, W2K);
        s1_c2 <= conj_mul(Y2, W1K);
        s1_c3 <= conj_mul(Y3, W3K);
      end
      if (s1_valid) begin
        s2_b0 <= cadd_half(s1_c0, s1_c1, 1'b0);
        s2_b1 <= cadd_half(s1_c0, s1_c1, 1'b1);
        s2_b2 <= cadd_half(s1_c2, s1_c3, 1'b0);
        s2_b3 <= rot_neg_j(cadd_half(s1_c3, s1_c2, 1'b1));
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every stage
  // samples its predecessor's value from before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      OUT_VALID <= 1'b0;
      A0        <= '0;
      A1        <= '0;
      A2        <= '0;
      A3        <= '0;
    end else if (IN_READY) begin
      s1_valid  <= IN_VALID;
      s2_valid  <= s1_valid;
      OUT_VALID <= s2_valid;
      if (s2_valid) begin
        A0 <= cadd_half(s2_b0, s2_b2, 1'b0);
        A2 <= cadd_half(s2_b0, s2_b2, 1'b1);
        A1 <= cadd_half(s2_b1, s2_b3, 1'b0);
        A3 <= cadd_half(s2_b1, s2_b3, 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_rad4_ifft_bfly.sv
// Directed and forward-model checks for the inverse radix-4 butterfly pipeline.
module tb_rad4_ifft_bfly;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] Y0, Y1, Y2, Y3;
  logic [31:0] W1K, W2K, W3K;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] A0, A1, A2, A3;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ONE = 32'h4000_0000;

  int tw_re[8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int tw_im[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

  rad4_ifft_bfly dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .W1K(W1K), .W2K(W2K), .W3K(W3K),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pack(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic int part_re(input logic [31:0] x);
    return int'($signed(x[31:16]));
  endfunction

  function automatic int part_im(input logic [31:0] x);
    return int'($signed(x[15:0]));
  endfunction

  // Forward twiddle multiply x * w, Q1.14 round-half-up.
  function automatic logic [31:0] fwd_mul(input int xr, input int xi, input int wr, input int wi);
    longint pr, pi;
    pr = longint'(xr) * wr - longint'(xi) * wi;
    pi = longint'(xr) * wi + longint'(xi) * wr;
    return pack(int'((pr + 8192) >>> 14), int'((pi + 8192) >>> 14));
  endfunction

  // Present one word into an empty pipeline and capture the first result.
  task automatic run_one(input logic [31:0] y0, input logic [31:0] y1,
                         input logic [31:0] y2, input logic [31:0] y3,
                         input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3,
                         output logic [31:0] r0, output logic [31:0] r1,
                         output logic [31:0] r2, output logic [31:0] r3,
                         output int lat);
    @(negedge CLK);
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    Y0 = y0; Y1 = y1; Y2 = y2; Y3 = y3;
    W1K = w1; W2K = w2; W3K = w3;
    lat = -1;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        IN_VALID = 1'b0;
        Y0 = 32'hDEAD_BEEF; Y1 = 32'hDEAD_BEEF; Y2 = 32'hDEAD_BEEF; Y3 = 32'hDEAD_BEEF;
      end
      if (OUT_VALID) begin
        lat = k;
        r0 = A0; r1 = A1; r2 = A2; r3 = A3;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    Y0 = 32'h0190_0000; Y1 = '0; Y2 = '0; Y3 = '0;
    W1K = ONE; W2K = ONE; W3K = ONE;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID);
    end
    n_checks++;
    if ({A0, A1, A2, A3} !== 128'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h %h %h %h want all 0", A0, A1, A2, A3);
    end
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
    seen = 0;
    repeat (5) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_blocks_input: OUT_VALID high %0d cycles want 0", seen);
    end
  endtask

  task automatic test_vector(input string name,
                             input logic [31:0] y0, input logic [31:0] y1,
                             input logic [31:0] y2, input logic [31:0] y3,
                             input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] r0, r1, r2, r3;
    int lat;
    run_one(y0, y1, y2, y3, w1, w2, w3, r0, r1, r2, r3, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL %s_latency: got %0d want 3", name, lat);
    end
    n_checks++;
    if (r0 !== e0) begin n_fail++; $display("FAIL %s_A0: got %h want %h", name, r0, e0); end
    n_checks++;
    if (r1 !== e1) begin n_fail++; $display("FAIL %s_A1: got %h want %h", name, r1, e1); end
    n_checks++;
    if (r2 !== e2) begin n_fail++; $display("FAIL %s_A2: got %h want %h", name, r2, e2); end
    n_checks++;
    if (r3 !== e3) begin n_fail++; $display("FAIL %s_A3: got %h want %h", name, r3, e3); end
  endtask

  task automatic test_back_to_back();
    int sent, recv, c;
    logic in_hs, out_hs, prev_stall, exp_ready;
    logic [127:0] held, exp_word;
    sent = 0; recv = 0; c = 0; prev_stall = 1'b0; held = '0;
    W1K = ONE; W2K = ONE; W3K = ONE;
    Y1 = '0; Y2 = '0; Y3 = '0;
    while (recv < 8 && c < 40) begin
      @(negedge CLK);
      OUT_READY = !(c >= 4 && c <= 6);
      IN_VALID = (sent < 8);
      Y0 = pack((sent + 1) * 400, (sent + 1) * 40);
      #1;
      exp_ready = !(c >= 4 && c <= 6);
      n_checks++;
      if (IN_READY !== exp_ready) begin
        n_fail++; $display("FAIL b2b_in_ready cycle %0d: got %b want %b", c, IN_READY, exp_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || {A0, A1, A2, A3} !== held) begin
          n_fail++;
          $display("FAIL b2b_hold cycle %0d: got v=%b %h want v=1 %h", c, OUT_VALID,
                   {A0, A1, A2, A3}, held);
        end
      end
      in_hs = IN_VALID && IN_READY;
      out_hs = OUT_VALID && OUT_READY;
      if (out_hs) begin
        exp_word = {4{pack((recv + 1) * 100, (recv + 1) * 10)}};
        n_checks++;
        if ({A0, A1, A2, A3} !== exp_word) begin
          n_fail++;
          $display("FAIL b2b_out%0d: got %h want %h", recv, {A0, A1, A2, A3}, exp_word);
        end
        recv++;
      end
      prev_stall = OUT_VALID && !OUT_READY;
      held = {A0, A1, A2, A3};
      if (in_hs) sent++;
      c++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    n_checks++;
    if (recv != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs want 8", recv);
    end
    recv = 0;
    repeat (5) begin
      @(negedge CLK);
      if (OUT_VALID) recv++;
    end
    n_checks++;
    if (recv != 0) begin
      n_fail++; $display("FAIL b2b_extra: got %0d extra outputs want 0", recv);
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    OUT_READY = 1'b1;
    W1K = ONE; W2K = ONE; W3K = ONE;
    Y1 = '0; Y2 = '0; Y3 = '0;
    @(negedge CLK); IN_VALID = 1'b1; Y0 = 32'h0190_0000;
    @(negedge CLK); Y0 = 32'h0320_0000;
    @(negedge CLK); RST = 1'b1; Y0 = 32'h04B0_0000;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k == 0) begin RST = 1'b0; IN_VALID = 1'b0; end
      if (OUT_VALID !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_out_valid: high %0d cycles want 0", seen);
    end
    n_checks++;
    if ({A0, A1, A2, A3} !== 128'h0) begin
      n_fail++; $display("FAIL flush_outputs: got %h want 0", {A0, A1, A2, A3});
    end
  endtask

  task automatic test_random_inverse();
    int ar[4], ai[4];
    int k1, k2, k3, ur, ui, dr, di, er, ei, worst;
    logic [31:0] y0, y1, y2, y3, r[4];
    int lat;
    for (int v = 0; v < 2000; v++) begin
      for (int i = 0; i < 4; i++) begin
        ar[i] = int'($urandom_range(4000)) - 2000;
        ai[i] = int'($urandom_range(4000)) - 2000;
      end
      k1 = int'($urandom_range(7)); k2 = int'($urandom_range(7)); k3 = int'($urandom_range(7));
      y0 = pack(ar[0] + ar[1] + ar[2] + ar[3], ai[0] + ai[1] + ai[2] + ai[3]);
      ur = ar[0] + ar[2] - ar[1] - ar[3];
      ui = ai[0] + ai[2] - ai[1] - ai[3];
      y1 = fwd_mul(ur, ui, tw_re[k2], tw_im[k2]);
      dr = ar[0] - ar[2]; di = ai[0] - ai[2];
      er = ar[1] - ar[3]; ei = ai[1] - ai[3];
      y2 = fwd_mul(dr + ei, di - er, tw_re[k1], tw_im[k1]);
      y3 = fwd_mul(dr - ei, di + er, tw_re[k3], tw_im[k3]);
      run_one(y0, y1, y2, y3, pack(tw_re[k1], tw_im[k1]), pack(tw_re[k2], tw_im[k2]),
              pack(tw_re[k3], tw_im[k3]), r[0], r[1], r[2], r[3], lat);
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if ((part_re(r[i]) - ar[i]) > worst) worst = part_re(r[i]) - ar[i];
        if ((ar[i] - part_re(r[i])) > worst) worst = ar[i] - part_re(r[i]);
        if ((part_im(r[i]) - ai[i]) > worst) worst = part_im(r[i]) - ai[i];
        if ((ai[i] - part_im(r[i])) > worst) worst = ai[i] - part_im(r[i]);
      end
      n_checks++;
      if (lat != 3 || worst > 2) begin
        n_fail++;
        $display("FAIL random_inverse vec %0d: got lat=%0d err=%0d want lat=3 err<=2 (A0 %h vs %0d,%0d)",
                 v, lat, worst, r[0], ar[0], ai[0]);
      end
    end
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    Y0 = '0; Y1 = '0; Y2 = '0; Y3 = '0;
    W1K = ONE; W2K = ONE; W3K = ONE;
    test_reset();
    test_vector("dc", 32'h0190_0000, 32'h0, 32'h0, 32'h0, ONE, ONE, ONE,
                32'h0064_0000, 32'h0064_0000, 32'h0064_0000, 32'h0064_0000);
    test_vector("twiddle_j", 32'h0, 32'h0000_0190, 32'h0, 32'h0, ONE, 32'h0000_4000, ONE,
                32'h0064_0000, 32'hFF9C_0000, 32'h0064_0000, 32'hFF9C_0000);
    // C1 saturates to (32767, 0), then two floor-halvings.
    test_vector("s1_saturation", 32'h0, 32'h7FFF_7FFF, 32'h0, 32'h0, ONE, 32'h4000_4000, ONE,
                32'h1FFF_0000, 32'hE000_0000, 32'h1FFF_0000, 32'hE000_0000);
    // B3J.re = -32768, so -j rotation must saturate B3.im to +32767.
    test_vector("neg_saturation", 32'h0, 32'h0, 32'h7FFF_0000, 32'h8000_0000, ONE, ONE, ONE,
                32'hFFFF_0000, 32'h0000_3FFF, 32'h0000_0000, 32'h0000_C000);
    test_back_to_back();
    test_reset_flush();
    test_random_inverse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
